// File: rtl/weight_sel_pkg.sv
// Shared types and helpers for the registered weight-slice selector.
// Holds the sequencer state encoding, index clamping and parameter sanity checks.
package weight_sel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SWEEP = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    localparam int unsigned DEF_OUT_SIZE = 32'd532;
    localparam int unsigned DEF_SEL_SIZE = 32'd28;
    localparam int unsigned DEF_SEL_BIT  = 32'd5;

    // True when an index of sel_bit bits can address every one of sel_size vectors.
    function automatic bit sel_bit_ok(input int unsigned sel_bit, input int unsigned sel_size);
        bit ok;
        if ((sel_size == 32'd0) || (sel_bit == 32'd0) || (sel_bit > 32'd30)) begin
            ok = 1'b0;
        end else begin
            ok = (sel_size <= (32'd1 << sel_bit));
        end
        return ok;
    endfunction

    // Out-of-range indices fall back to vector 0.
    function automatic int unsigned clamp_idx(input int unsigned idx, input int unsigned sel_size);
        int unsigned res;
        if (idx >= sel_size) begin
            res = 32'd0;
        end else begin
            res = idx;
        end
        return res;
    endfunction

    localparam bit DEF_CFG_OK = sel_bit_ok(DEF_SEL_BIT, DEF_SEL_SIZE);

endpackage

// File: rtl/weight_slice_mux.sv
// Combinational slice selector: picks one OUT_SIZE-bit vector out of a packed bus.
// Indices beyond the last vector select vector 0 and report index 0.
module weight_slice_mux
    import weight_sel_pkg::*;
#(
    parameter int unsigned OUT_SIZE = DEF_OUT_SIZE,
    parameter int unsigned SEL_SIZE = DEF_SEL_SIZE,
    parameter int unsigned SEL_BIT  = DEF_SEL_BIT
) (
    input  logic [OUT_SIZE*SEL_SIZE-1:0] weights_i,
    input  logic [SEL_BIT-1:0]           sel_i,
    output logic [OUT_SIZE-1:0]          vec_o,
    output logic [SEL_BIT-1:0]           sel_o
);

    int unsigned clamped_s;

    // Clamp the index, then take the matching part-select.
    always_comb begin
        clamped_s = clamp_idx(32'(sel_i), SEL_SIZE);
        sel_o     = SEL_BIT'(clamped_s);
        vec_o     = weights_i[OUT_SIZE*clamped_s +: OUT_SIZE];
    end

endmodule

// File: rtl/weight_select_seq.sv
// Handshaked weight-vector source: emits one manually selected vector or a full
// 0..SEL_SIZE-1 sweep over a valid/ready stream, with abort and back-pressure.
module weight_select_seq
    import weight_sel_pkg::*;
#(
    parameter int unsigned OUT_SIZE = DEF_OUT_SIZE,
    parameter int unsigned SEL_SIZE = DEF_SEL_SIZE,
    parameter int unsigned SEL_BIT  = DEF_SEL_BIT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [OUT_SIZE*SEL_SIZE-1:0] In,
    input  logic [SEL_BIT-1:0]           sel_in,
    input  logic                         sel_load,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         out_ready,
    output logic [OUT_SIZE-1:0]          Out,
    output logic                         out_valid,
    output logic [SEL_BIT-1:0]           out_sel,
    output logic                         busy,
    output logic                         done
);

    localparam bit                 CFG_OK   = sel_bit_ok(SEL_BIT, SEL_SIZE);
    localparam logic [SEL_BIT-1:0] LAST_IDX = SEL_BIT'(SEL_SIZE - 32'd1);
    localparam logic [SEL_BIT-1:0] IDX_ZERO = {SEL_BIT{1'b0}};
    localparam logic [SEL_BIT-1:0] IDX_ONE  = SEL_BIT'(1'b1);

    if (!CFG_OK) begin : g_cfg_err
        $error("weight_select_seq: SEL_BIT too narrow for SEL_SIZE");
    end

    state_t               state_q, state_d;
    logic [SEL_BIT-1:0]   idx_q, idx_d;
    logic [OUT_SIZE-1:0]  out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic [SEL_BIT-1:0]   out_sel_q, out_sel_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [SEL_BIT-1:0]   mux_sel_s;
    logic [SEL_BIT-1:0]   mux_clamp_s;
    logic [OUT_SIZE-1:0]  mux_vec_s;
    logic                 slot_free_s;
    logic                 xfer_s;

    assign slot_free_s = !out_valid_q || out_ready;
    assign xfer_s      = out_valid_q && out_ready;

    // Index presented to the mux: a sweep always opens at 0, otherwise the manual index.
    always_comb begin
        mux_sel_s = idx_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                mux_sel_s = IDX_ZERO;
            end else begin
                mux_sel_s = sel_in;
            end
        end else begin
            mux_sel_s = idx_q;
        end
    end

    weight_slice_mux #(
        .OUT_SIZE (OUT_SIZE),
        .SEL_SIZE (SEL_SIZE),
        .SEL_BIT  (SEL_BIT)
    ) u_mux (
        .weights_i (In),
        .sel_i     (mux_sel_s),
        .vec_o     (mux_vec_s),
        .sel_o     (mux_clamp_s)
    );

    // Sequencer next-state and output-register next values.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && slot_free_s) begin
                    out_d       = mux_vec_s;
                    out_sel_d   = mux_clamp_s;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    if (SEL_SIZE == 32'd1) begin
                        idx_d   = IDX_ZERO;
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d   = IDX_ONE;
                        state_d = ST_SWEEP;
                    end
                end else if (sel_load && slot_free_s) begin
                    out_d       = mux_vec_s;
                    out_sel_d   = mux_clamp_s;
                    out_valid_d = 1'b1;
                end else if (xfer_s) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end

            ST_SWEEP: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    idx_d       = IDX_ZERO;
                    state_d     = ST_IDLE;
                end else if (slot_free_s) begin
                    out_d       = mux_vec_s;
                    out_sel_d   = mux_clamp_s;
                    out_valid_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = idx_q;
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                    end
                end else begin
                    state_d = ST_SWEEP;
                end
            end

            ST_DRAIN: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    idx_d       = IDX_ZERO;
                    state_d     = ST_IDLE;
                end else if (xfer_s) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    idx_d       = IDX_ZERO;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                idx_d       = IDX_ZERO;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= IDX_ZERO;
            out_q       <= {OUT_SIZE{1'b0}};
            out_valid_q <= 1'b0;
            out_sel_q   <= IDX_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign Out       = out_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_weight_select_seq.sv
// Self-checking bench for weight_select_seq: directed scenarios plus randomized traffic
// compared against a queue-based model of the stream the consumer should see.
module tb_weight_select_seq;

    localparam int OUT_SIZE = 8;
    localparam int SEL_SIZE = 28;
    localparam int SEL_BIT  = 5;

    logic                         clk;
    logic                         rst_n;
    logic [OUT_SIZE*SEL_SIZE-1:0] wvec;
    logic [SEL_BIT-1:0]           sel_in;
    logic                         sel_load, start, abort, out_ready;
    logic [OUT_SIZE-1:0]          dut_out;
    logic                         out_valid, busy, done;
    logic [SEL_BIT-1:0]           out_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the consumer sees, plus the indices a sweep still owes.
    logic [OUT_SIZE-1:0] m_out;
    logic [SEL_BIT-1:0]  m_sel;
    logic                m_valid, m_active, m_done;
    int                  pending[$];

    weight_select_seq #(.OUT_SIZE(OUT_SIZE), .SEL_SIZE(SEL_SIZE), .SEL_BIT(SEL_BIT)) dut (
        .clk(clk), .rst_n(rst_n), .In(wvec), .sel_in(sel_in), .sel_load(sel_load),
        .start(start), .abort(abort), .out_ready(out_ready), .Out(dut_out),
        .out_valid(out_valid), .out_sel(out_sel), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void set_default_weights();
        for (int k = 0; k < SEL_SIZE; k++) wvec[k*OUT_SIZE +: OUT_SIZE] = 8'(8'h10 + k);
    endfunction

    function automatic void model_reset();
        m_out = '0; m_sel = '0; m_valid = 1'b0; m_active = 1'b0; m_done = 1'b0;
        pending.delete();
    endfunction

    function automatic void emit(input int k);
        m_out   = wvec[k*OUT_SIZE +: OUT_SIZE];
        m_sel   = 5'(k);
        m_valid = 1'b1;
    endfunction

    // One clock edge of the stream, evaluated from the inputs about to be sampled.
    function automatic void model_advance();
        logic slot, xfer;
        slot   = !m_valid || out_ready;
        xfer   = m_valid && out_ready;
        m_done = 1'b0;
        if (m_active) begin
            if (abort) begin
                m_valid = 1'b0; m_active = 1'b0; pending.delete();
            end else if (pending.size() != 0) begin
                if (slot) emit(pending.pop_front());
            end else if (xfer) begin
                m_valid = 1'b0; m_done = 1'b1; m_active = 1'b0;
            end
        end else if (start && slot) begin
            pending.delete();
            for (int k = 1; k < SEL_SIZE; k++) pending.push_back(k);
            emit(0);
            m_active = 1'b1;
        end else if (sel_load && slot) begin
            emit((int'(sel_in) < SEL_SIZE) ? int'(sel_in) : 0);
        end else if (xfer) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic step(input logic st, input logic sl, input logic [4:0] si,
                        input logic ab, input logic rdy);
        @(negedge clk);
        start = st; sel_load = sl; sel_in = si; abort = ab; out_ready = rdy;
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sel_load = 1'b0; sel_in = '0; abort = 1'b0; out_ready = 1'b0;
        set_default_weights();
        model_reset();
        #12;
        n_checks++;
        if ({dut_out, out_valid, out_sel, busy, done} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset: out=%h v=%b sel=%0d busy=%b done=%b, required all zero",
                     dut_out, out_valid, out_sel, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_manual();
        int dones = 0;
        step(1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
        n_checks++;
        if (dut_out !== 8'h15 || out_sel !== 5'd5 || out_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL manual_load: out=%h sel=%0d v=%b busy=%b, required 15/5/1/0",
                     dut_out, out_sel, out_valid, busy);
        end
        dones += int'(done);
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        dones += int'(done);
        n_checks++;
        if (out_valid !== 1'b0 || dut_out !== 8'h15) begin
            n_fail++;
            $display("FAIL manual_drop: v=%b out=%h, required v=0 out=15", out_valid, dut_out);
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL manual_done: %0d done pulses, required 0", dones);
        end
    endtask

    task automatic test_clamp();
        step(1'b0, 1'b1, 5'd30, 1'b0, 1'b1);
        n_checks++;
        if (dut_out !== 8'h10 || out_sel !== 5'd0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp: out=%h sel=%0d v=%b, required 10/0/1", dut_out, out_sel, out_valid);
        end
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic test_sweep();
        int dones = 0;
        step(1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int k = 0; k < SEL_SIZE; k++) begin
            if (k > 0) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            dones += int'(done);
            n_checks++;
            if (dut_out !== 8'(8'h10 + k) || out_sel !== 5'(k) || out_valid !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_k%0d: out=%h sel=%0d v=%b busy=%b, required %h/%0d/1/1",
                         k, dut_out, out_sel, out_valid, busy, 8'(8'h10 + k), k);
            end
        end
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || dones != 0) begin
            n_fail++;
            $display("FAIL sweep_done: done=%b busy=%b v=%b early_dones=%0d, required 1/0/0/0",
                     done, busy, out_valid, dones);
        end
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_after: done=%b busy=%b, required 0/0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        step(1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 7; k++) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int h = 0; h < 3; h++) begin
            step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            n_checks++;
            if (dut_out !== 8'h17 || out_sel !== 5'd7 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: out=%h sel=%0d v=%b, required 17/7/1",
                         h, dut_out, out_sel, out_valid);
            end
        end
        for (int k = 8; k < SEL_SIZE + 1; k++) begin
            step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            n_checks++;
            if ({dut_out, out_valid, out_sel, busy, done} !== {m_out, m_valid, m_sel, m_active, m_done}) begin
                n_fail++;
                $display("FAIL bp_resume%0d: out=%h v=%b sel=%0d busy=%b done=%b, required %h/%b/%0d/%b/%b",
                         k, dut_out, out_valid, out_sel, busy, done, m_out, m_valid, m_sel, m_active, m_done);
            end
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: done=%b, required 1", done);
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        step(1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        dones += int'(done);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || dut_out !== 8'h1C) begin
            n_fail++;
            $display("FAIL abort: v=%b busy=%b out=%h, required 0/0/1c", out_valid, busy, dut_out);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            dones += int'(done) + int'(busy) + int'(out_valid);
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d stray done/busy/valid cycles, required 0", dones);
        end
    endtask

    task automatic test_collision();
        step(1'b1, 1'b1, 5'd3, 1'b0, 1'b1);
        n_checks++;
        if (dut_out !== 8'h10 || out_sel !== 5'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL collision: out=%h sel=%0d busy=%b, required 10/0/1", dut_out, out_sel, busy);
        end
        for (int k = 0; k < SEL_SIZE + 2; k++) begin
            step(1'b0, 1'b1, 5'd3, 1'b0, 1'b1);
            n_checks++;
            if ({dut_out, out_valid, out_sel, busy, done} !== {m_out, m_valid, m_sel, m_active, m_done}) begin
                n_fail++;
                $display("FAIL collision_seq%0d: out=%h v=%b sel=%0d busy=%b done=%b, required %h/%b/%0d/%b/%b",
                         k, dut_out, out_valid, out_sel, busy, done, m_out, m_valid, m_sel, m_active, m_done);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < SEL_SIZE; k++) wvec[k*OUT_SIZE +: OUT_SIZE] = 8'($urandom);
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), 5'($urandom),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0));
            n_checks++;
            if ({dut_out, out_valid, out_sel, busy, done} !== {m_out, m_valid, m_sel, m_active, m_done}) begin
                n_fail++;
                $display("FAIL random_c%0d: out=%h v=%b sel=%0d busy=%b done=%b, required %h/%b/%0d/%b/%b",
                         c, dut_out, out_valid, out_sel, busy, done, m_out, m_valid, m_sel, m_active, m_done);
            end
        end
        set_default_weights();
        step(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dut_out, out_valid, out_sel, busy, done} !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: out=%h v=%b sel=%0d busy=%b done=%b, required all zero",
                     dut_out, out_valid, out_sel, busy, done);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        n_checks++;
        if (dut_out !== 8'h10 || out_sel !== 5'd0 || out_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: out=%h sel=%0d v=%b busy=%b, required 10/0/1/1",
                     dut_out, out_sel, out_valid, busy);
        end
        for (int k = 0; k < SEL_SIZE + 1; k++) begin
            step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            n_checks++;
            if ({dut_out, out_valid, out_sel, busy, done} !== {m_out, m_valid, m_sel, m_active, m_done}) begin
                n_fail++;
                $display("FAIL restart_seq%0d: out=%h v=%b sel=%0d busy=%b done=%b, required %h/%b/%0d/%b/%b",
                         k, dut_out, out_valid, out_sel, busy, done, m_out, m_valid, m_sel, m_active, m_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_clamp();
        test_sweep();
        test_backpressure();
        test_abort();
        test_collision();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_select_seq.md
Name: weight_select_seq

Overview:
Registered, handshaked successor to the combinational weight-slice selector.
- Holds a flat bus of SEL_SIZE weight vectors, each OUT_SIZE bits wide.
- Delivers either one manually selected vector or an automatic sweep of all vectors (index 0..SEL_SIZE-1) over a valid/ready stream.
- Sits between the weight storage and the MAC array loader; replaces free-running combinational selection with a cycle-accurate, back-pressurable source.

Parameters:
- OUT_SIZE, 532, width of one weight vector in bits
- SEL_SIZE, 28, number of vectors packed on In
- SEL_BIT, 5, index width; must satisfy 2**SEL_BIT >= SEL_SIZE

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- In  input  OUT_SIZE*SEL_SIZE  packed vectors; vector k occupies [OUT_SIZE*(k+1)-1 : OUT_SIZE*k]
- sel_in  input  SEL_BIT  manual index
- sel_load  input  1  request a manual single-vector load
- start  input  1  request a full sweep 0..SEL_SIZE-1
- abort  input  1  cancel an active sweep
- out_ready  input  1  consumer ready
- Out  output  OUT_SIZE  registered selected vector
- out_valid  output  1  Out is valid
- out_sel  output  SEL_BIT  index of the vector currently on Out
- busy  output  1  high in SWEEP or DRAIN
- done  output  1  one-cycle pulse when a sweep's last vector is accepted

Behaviour:
- Reset (async, rst_n=0): Out=0, out_valid=0, out_sel=0, busy=0, done=0, idx=0, state=IDLE.
- Definitions:
  - Slot free = (out_valid==0) || out_ready.
  - Transfer = out_valid && out_ready.
- Out register loads only on a load event. In is sampled on that edge; later In changes do not alter Out.
- Index clamp: any index >= SEL_SIZE selects vector 0 and sets out_sel=0.
- Latency: a request at edge N gives Out/out_valid valid after edge N+1 (one register stage).
- Output hold: while out_valid && !out_ready, Out and out_sel hold stable.
- States: IDLE, SWEEP, DRAIN.
- IDLE:
  - start && slot free: load vector 0, out_sel=0, out_valid=1, idx=1, busy=1, go SWEEP. If SEL_SIZE==1, go DRAIN instead.
  - else sel_load && slot free: load clamp(sel_in), out_valid=1, stay IDLE.
  - start and sel_load together: start wins; sel_load is dropped.
  - Transfer with no new load: out_valid=0.
  - Requests while the slot is not free are ignored, not queued.
- SWEEP:
  - Each cycle with slot free: load vector idx, out_sel=idx, out_valid=1, idx+1.
  - When idx==SEL_SIZE-1 is loaded, go DRAIN.
  - Back-to-back: one vector per cycle when out_ready is held high.
  - start and sel_load are ignored.
- DRAIN: on transfer, out_valid=0, done=1 for one cycle, busy=0, idx=0, go IDLE.
- abort in SWEEP or DRAIN (highest priority):
  - Next edge: out_valid=0, busy=0, idx=0, done stays 0, state=IDLE.
  - Out keeps its last value.
  - abort in IDLE has no effect.
- done asserts only on a completed sweep, never for a manual load.
- Reset mid-sweep: immediately returns to reset values; no done.
- idx never wraps past SEL_SIZE-1 within a sweep; each sweep restarts at 0.

Decomposition:
- Package weight_sel_pkg:
  - state enum (IDLE, SWEEP, DRAIN)
  - function clamp_idx(idx, SEL_SIZE)
  - localparam checks SEL_BIT vs SEL_SIZE
- One sub-module, weight_slice_mux:
  - purely combinational, parametrised by OUT_SIZE/SEL_SIZE/SEL_BIT
  - indexed part-select with the out-of-range -> 0 rule
  - feeds the Out register in weight_select_seq

Test Plan:
Parameters OUT_SIZE=8, SEL_SIZE=28, SEL_BIT=5; vector k = 8'h10+k.
- Manual: sel_in=5, sel_load one cycle, out_ready=1 -> next cycle Out=8'h15, out_sel=5, out_valid=1; one cycle later out_valid=0; done never asserts.
- Clamp: sel_in=30, sel_load -> Out=8'h10, out_sel=0.
- Sweep: start, out_ready=1 -> 28 consecutive cycles Out=8'h10..8'h2B, out_sel 0..27; done pulses exactly once, on the cycle after the 8'h2B transfer; busy low afterwards.
- Back-pressure: sweep with out_ready low for 3 cycles at out_sel=7 -> Out holds 8'h17 and out_valid stays 1; sequence resumes at 8 with no skip or duplicate.
- Abort and collision:
  - abort at out_sel=12 -> next cycle out_valid=0, busy=0, no done.
  - start and sel_load(sel_in=3) in the same IDLE cycle -> sweep begins at 0; 8'h13 is not emitted first.
- Async reset mid-sweep: rst_n low between edges -> outputs reach reset values immediately. After release, start -> sweep restarts at out_sel=0.
